// File: rtl/wb_pkg.sv
// Shared Wishbone burst definitions: cycle-type codes, master state encoding
// and the per-beat cycle-type selection.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_DONE
  } state_t;

  // Single-beat bursts are classic cycles; multi-beat bursts flag their last beat
  function automatic logic [2:0] cti_for(input logic single, input logic last);
    if (single) return CTI_CLASSIC;
    if (last) return CTI_EOB;
    return CTI_INCR;
  endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Acknowledge watchdog: counts strobed cycles without an ack and flags expiry
// once TIMEOUT such cycles have elapsed.
module wb_ack_timer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (clear || !enable) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (count != CW'(TIMEOUT)) begin
      count   <= count + CW'(1);
      expired <= (count == CW'(TIMEOUT - 1));
    end
  end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone incrementing-burst master: accepts one read or write command,
// streams its beats over a single held cycle, then pulses done (err on timeout).
module wb_burst_master
  import wb_pkg::*;
#(
  parameter int unsigned dw      = 32,
  parameter int unsigned APP_AW  = 26,
  parameter int unsigned BURST_W = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                sys_clk,
  input  logic                sys_resetn,
  input  logic                sdr_init_done,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [APP_AW-1:0]   cmd_addr,
  input  logic [BURST_W-1:0]  cmd_len,
  input  logic [dw-1:0]       wr_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic [dw-1:0]       rd_data,
  output logic                rd_valid,
  output logic                done,
  output logic                err,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [APP_AW-1:0]   wb_addr_o,
  output logic [dw/8-1:0]     wb_sel_o,
  output logic [dw-1:0]       wb_dat_o,
  output logic [2:0]          wb_cti_o,
  input  logic                wb_ack_i,
  input  logic [dw-1:0]       wb_dat_i
);

  localparam int unsigned STEP = dw / 8;

  state_t               state;
  logic                 we_r;
  logic [BURST_W-1:0]   len_r;
  logic [BURST_W-1:0]   beat_cnt;
  logic                 expired;
  logic                 ack_v;
  logic                 last;
  logic                 wr_fire;

  // Acks outside a strobed cycle carry no meaning and are dropped here
  assign ack_v   = wb_ack_i && wb_stb_o;
  assign last    = (beat_cnt == len_r);
  assign wr_fire = wr_valid && wr_ready;

  assign cmd_ready = sys_resetn && (state == ST_IDLE) && sdr_init_done;
  assign wr_ready  = (state == ST_XFER) && we_r && !expired &&
                     (!wb_stb_o || (ack_v && !last));

  wb_ack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_ack_timer (
    .clk     (sys_clk),
    .rst_n   (sys_resetn),
    .clear   (ack_v),
    .enable  ((state == ST_XFER) && wb_stb_o),
    .expired (expired)
  );

  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state     <= ST_IDLE;
      we_r      <= 1'b0;
      len_r     <= '0;
      beat_cnt  <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_addr_o <= '0;
      wb_sel_o  <= '0;
      wb_dat_o  <= '0;
      wb_cti_o  <= CTI_CLASSIC;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state     <= ST_XFER;
            we_r      <= cmd_we;
            len_r     <= cmd_len;
            beat_cnt  <= '0;
            wb_addr_o <= cmd_addr;
            wb_cyc_o  <= 1'b1;
            wb_we_o   <= cmd_we;
            wb_sel_o  <= '1;
            wb_cti_o  <= cti_for(cmd_len == '0, cmd_len == '0);
            // Reads strobe at once; writes wait for their first beat
            wb_stb_o  <= !cmd_we;
          end
        end
        ST_XFER: begin
          if (expired) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            err      <= 1'b1;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            wb_cti_o <= CTI_CLASSIC;
          end else begin
            if (ack_v) begin
              if (!we_r) begin
                rd_data  <= wb_dat_i;
                rd_valid <= 1'b1;
              end
              if (last) begin
                state    <= ST_DONE;
                done     <= 1'b1;
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
                wb_we_o  <= 1'b0;
                wb_sel_o <= '0;
                wb_cti_o <= CTI_CLASSIC;
              end else begin
                beat_cnt  <= beat_cnt + BURST_W'(1);
                wb_addr_o <= wb_addr_o + APP_AW'(STEP);
                wb_cti_o  <= cti_for(1'b0, (beat_cnt + BURST_W'(1)) == len_r);
              end
            end
            // Write strobe follows beat occupancy: load on fire, release on ack
            if (we_r && !(ack_v && last)) begin
              if (wr_fire) begin
                wb_dat_o <= wr_data;
                wb_stb_o <= 1'b1;
              end else if (ack_v) begin
                wb_stb_o <= 1'b0;
              end
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed and randomized bursts against a Wishbone slave model; every acked
// beat is compared with the address/cti/data sequence derived from the command.
module tb_wb_burst_master;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 26;
  localparam int unsigned BW = 4;
  localparam int unsigned TO = 1024;

  logic            sys_clk = 1'b0;
  logic            sys_resetn;
  logic            sdr_init_done;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_we;
  logic [AW-1:0]   cmd_addr;
  logic [BW-1:0]   cmd_len;
  logic [DW-1:0]   wr_data;
  logic            wr_valid;
  logic            wr_ready;
  logic [DW-1:0]   rd_data;
  logic            rd_valid;
  logic            done;
  logic            err;
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic [AW-1:0]   wb_addr_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [DW-1:0]   wb_dat_o;
  logic [2:0]      wb_cti_o;
  logic            wb_ack_i;
  logic [DW-1:0]   wb_dat_i;

  int checks   = 0;
  int failures = 0;

  wb_burst_master #(
    .dw      (DW),
    .APP_AW  (AW),
    .BURST_W (BW),
    .TIMEOUT (TO)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_resetn    (sys_resetn),
    .sdr_init_done (sdr_init_done),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_we        (cmd_we),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .done          (done),
    .err           (err),
    .wb_cyc_o      (wb_cyc_o),
    .wb_stb_o      (wb_stb_o),
    .wb_we_o       (wb_we_o),
    .wb_addr_o     (wb_addr_o),
    .wb_sel_o      (wb_sel_o),
    .wb_dat_o      (wb_dat_o),
    .wb_cti_o      (wb_cti_o),
    .wb_ack_i      (wb_ack_i),
    .wb_dat_i      (wb_dat_i)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_cti(input int len, input int beat);
    if (len == 0) return 3'b000;
    return (beat == len) ? 3'b111 : 3'b010;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {cmd_ready, wr_ready, rd_valid, done, err,
                          wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o}, 0);
    check({tag, "_addr"}, wb_addr_o, 0);
    check({tag, "_data"}, {wb_dat_o, rd_data}, 0);
  endtask

  // One command, slave acks with probability ack_pct; rst_at>0 resets after that ack
  task automatic run_burst(input logic we, input logic [AW-1:0] addr, input int len,
                           input int ack_pct, input int wrv_pct, input int stall_at,
                           input int rst_at, input bit drop_init);
    logic [DW-1:0] data[$];
    logic [DW-1:0] rd_exp;
    logic [AW-1:0] ea;
    int  acks     = 0;
    int  consumed = 0;
    bit  rd_pend  = 0;
    bit  fin      = 0;
    bit  stalled;
    for (int i = 0; i <= len; i++) data.push_back($urandom);
    @(negedge sys_clk);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_len   = BW'(len);
    wr_valid  = 1'b0;
    wb_ack_i  = 1'b0;
    #1 check("cmd_ready_idle", cmd_ready, 1);
    for (int it = 0; it < 600 && !fin; it++) begin
      @(negedge sys_clk);
      cmd_valid = 1'b0;
      if (drop_init && it == 1) sdr_init_done = 1'b0;
      if (!we) begin
        check("rd_valid", rd_valid, rd_pend);
        if (rd_pend) check("rd_data", rd_data, rd_exp);
      end
      if (acks == len + 1) begin
        check("done_pulse", done, 1);
        check("done_err", err, 0);
        check("cyc_end", wb_cyc_o, 0);
        check("cti_end", wb_cti_o, 0);
        if (we) check("beats_consumed", consumed, len + 1);
        fin = 1;
      end else begin
        check("cyc_hold", wb_cyc_o, 1);
        check("done_low", done, 0);
        if (stall_at >= 0 && it > stall_at && it < stall_at + 5)
          check("stall_stb", wb_stb_o, 0);
      end
      if (!fin) begin
        wb_ack_i = wb_stb_o ? ($urandom_range(99) < ack_pct) : ($urandom_range(3) == 0);
        wb_dat_i = $urandom;
        if (we) begin
          stalled  = (stall_at >= 0 && it >= stall_at && it < stall_at + 5);
          wr_valid = stalled ? 1'b0 : ($urandom_range(99) < wrv_pct);
          wr_data  = (consumed <= len) ? data[consumed] : $urandom;
        end
        #1;
        rd_pend = 0;
        if (wb_stb_o && wb_ack_i) begin
          ea = addr + AW'(4 * acks);
          check("beat_addr", wb_addr_o, ea);
          check("beat_cti", wb_cti_o, exp_cti(len, acks));
          check("beat_we", wb_we_o, we);
          check("beat_sel", wb_sel_o, 4'hF);
          if (we) check("beat_wdata", wb_dat_o, data[acks]);
          else begin
            rd_pend = 1;
            rd_exp  = wb_dat_i;
          end
          acks++;
          if (acks == rst_at) begin
            #2 sys_resetn = 1'b0;
            #1 check_all_zero("reset_mid");
            return;
          end
        end
        if (we && wr_valid && wr_ready) consumed++;
      end
    end
    check("burst_bound", fin, 1);
    wb_ack_i = 1'b0;
    wr_valid = 1'b0;
    @(negedge sys_clk);
    check("done_one_cycle", done, 0);
    check("cmd_ready_after", cmd_ready, !drop_init);
    sdr_init_done = 1'b1;
  endtask

  initial begin
    int  stb_cnt;
    bit  seen;
    sys_resetn    = 1'b0;
    sdr_init_done = 1'b1;
    cmd_valid     = 1'b0;
    cmd_we        = 1'b0;
    cmd_addr      = '0;
    cmd_len       = '0;
    wr_data       = '0;
    wr_valid      = 1'b0;
    wb_ack_i      = 1'b0;
    wb_dat_i      = '0;
    #12 check_all_zero("reset_init");
    @(negedge sys_clk);
    sys_resetn = 1'b1;

    run_burst(1'b1, 26'h100, 3, 100, 100, -1, -1, 0);
    run_burst(1'b0, 26'h2000, 0, 100, 100, -1, -1, 0);
    run_burst(1'b1, 26'h300, 3, 100, 100, 2, -1, 0);
    run_burst(1'b0, 26'h3FFFFFC, 1, 70, 100, -1, -1, 0);
    run_burst(1'b0, 26'h500, 5, 80, 100, -1, -1, 1);

    // Controller not initialised: commands stay blocked
    sdr_init_done = 1'b0;
    @(negedge sys_clk);
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_len   = 4'd2;
    #1 check("cmd_ready_noinit", cmd_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      check("cyc_noinit", wb_cyc_o, 0);
    end
    cmd_valid     = 1'b0;
    sdr_init_done = 1'b1;

    // Silent slave: the watchdog must end the burst with err
    @(negedge sys_clk);
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 26'h40;
    cmd_len   = 4'd2;
    wb_ack_i  = 1'b0;
    #1 check("cmd_ready_to", cmd_ready, 1);
    stb_cnt = 0;
    seen    = 0;
    for (int it = 0; it < 1100 && !seen; it++) begin
      @(negedge sys_clk);
      cmd_valid = 1'b0;
      if (done === 1'b1) seen = 1;
      else if (wb_stb_o === 1'b1) stb_cnt++;
    end
    check("timeout_seen", seen, 1);
    check("timeout_err", err, 1);
    check("timeout_cyc", wb_cyc_o, 0);
    check("timeout_stb", wb_stb_o, 0);
    check("timeout_wait", (stb_cnt >= int'(TO) && stb_cnt <= int'(TO) + 1), 1);
    @(negedge sys_clk);
    check("timeout_done_low", {done, err}, 0);

    for (int n = 0; n < 8; n++)
      run_burst(1'($urandom_range(1)), AW'($urandom), $urandom_range(15),
                $urandom_range(100, 40), $urandom_range(100, 50), -1, -1, 0);

    // Reset landing in the middle of a burst abandons it silently
    run_burst(1'b1, 26'h600, 3, 100, 100, -1, 2, 0);
    wb_ack_i = 1'b0;
    wr_valid = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      check("post_reset_quiet", {done, wb_cyc_o}, 0);
    end
    check("post_reset_ready", cmd_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
